nios_system_sysid_ext: RTL
==========================

Name: nios_system_sysid_ext

Overview:
Parametrised successor to the system-ID slave. It is an Avalon-MM slave on the Nios system bus.
- Returns the system ID, build timestamp and clock frequency as constants.
- Adds a free-running cycle counter with coherent 64-bit snapshot reads, an uptime-seconds counter, a scratch register and a control/status register.
- Software uses it for ID checks, profiling and uptime reporting.

Parameters:
SYSTEM_ID, 32'h0000_0000, value returned at word 0
TIMESTAMP, 32'd1579698382, build timestamp returned at word 1
CLK_FREQ_HZ, 50000000, clock frequency; returned at word 2; uptime prescaler terminal count; must be >= 2
CNT_W, 64, cycle counter width; legal range 33..64

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word address
read  in  1  read strobe, one cycle per access
write  in  1  write strobe, one cycle per access
writedata  in  32  write data
byteenable  in  4  byte lanes for write
readdata  out  32  registered read data

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clock, reset). No waitrequest.
- Read latency is fixed at 1: readdata is updated on the edge where read=1 and is valid the following cycle. It holds its value otherwise.
- Writes take effect on the edge where write=1.
- Reset clears readdata, the cycle counter, snapshot, prescaler, seconds counter, scratch, freeze bit and wrap flag to 0.
- Address map:
  - 0 ID: RO, returns SYSTEM_ID.
  - 1 TIMESTAMP: RO.
  - 2 FREQ: RO, returns CLK_FREQ_HZ.
  - 3 CYCLE_LO:
    - Read returns counter[31:0] and, on the same edge, captures counter[CNT_W-1:32] into the snapshot.
    - Write loads counter[31:0] with byteenable applied.
  - 4 CYCLE_HI:
    - Read returns the snapshot, zero-extended.
    - Write loads counter[CNT_W-1:32] from writedata (bits above CNT_W-33 ignored), with byteenable applied.
  - 5 UPTIME_SEC: RO, 32-bit seconds counter.
  - 6 SCRATCH: RW, per-byte byteenable.
  - 7 CONTROL:
    - bit0 CLEAR: write 1 zeroes the counter, prescaler and seconds on that edge; reads 0.
    - bit1 FREEZE: RW; while 1, counter, prescaler and seconds hold.
    - bit8 WRAP: sticky; set when the counter wraps all-ones to 0; write 1 clears it.
    - Other bits read 0 and ignore writes.
    - Byte-enables apply: lane 0 carries bits 1:0, lane 1 carries bit 8.
- Counter: increments by 1 per cycle when not frozen and not being written or cleared. It wraps modulo 2^CNT_W.
- Prescaler: counts 0..CLK_FREQ_HZ-1. On reaching the terminal value it returns to 0 and the seconds counter increments (wraps at 2^32).
- Priority on any single edge, highest first: reset > CLEAR > CYCLE_LO/HI write > increment.
- A partial load writes only the addressed half. The other half keeps its current value and does not increment that cycle.
- WRAP: hardware set beats a write-1-to-clear on the same edge (flag stays 1). CLEAR does not affect WRAP.
- Read and write both asserted on the same edge: the write is performed; readdata returns the pre-write value.
- Reset asserted mid-sequence: any pending snapshot is discarded and the snapshot reads 0.

Decomposition:
- Package nios_system_sysid_pkg holds:
  - the address constants ADDR_ID..ADDR_CONTROL;
  - the CONTROL bit positions CTRL_CLEAR_BIT=0, CTRL_FREEZE_BIT=1, CTRL_WRAP_BIT=8.
- One sub-module, nios_system_sysid_uptime. It contains the prescaler and seconds counter, with inputs clear and freeze and a 32-bit seconds output.
- Everything else stays in the top level.

Test Plan:
- Reset, then read addresses 0..7 -> ID=SYSTEM_ID, TIMESTAMP=1579698382, FREQ=CLK_FREQ_HZ, SCRATCH=0, CONTROL=0. readdata is 0 before the first read and valid exactly 1 cycle after read.
- Coherent snapshot:
  - Write CYCLE_HI=0x0000_0001 and CYCLE_LO=0xFFFF_FFFE.
  - Read LO 5 cycles later -> LO=0x0000_0003 (counter 0x2_0000_0003).
  - Read HI after 100 further cycles -> HI=0x0000_0002, not the then-live value.
- Wrap flag:
  - With CNT_W=40, load all-ones, wait 1 cycle -> counter 0, CONTROL bit8=1.
  - Write CONTROL=0x100 on the wrap edge -> bit8 stays 1.
  - A later write of 0x100 -> bit8=0.
- Uptime with CLK_FREQ_HZ=10:
  - After reset, run 35 cycles -> UPTIME_SEC=3.
  - Set FREEZE for 50 cycles, then clear it; after 20 more cycles -> UPTIME_SEC=5.
  - Write CLEAR -> UPTIME_SEC=0 and CYCLE_LO small.
- Scratch byteenable: write 0xAABBCCDD with byteenable 4'b0101 over 0x11223344 -> SCRATCH reads 0x11BB33DD.
- Simultaneous read and write to SCRATCH holding 0x5 with data 0x9 -> readdata=0x5; next read -> 0x9.

Source files
------------

// File: rtl/nios_system_sysid_pkg.sv
// Shared address map, CONTROL bit positions and byte-lane helper for the
// extended system-ID slave.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ADDR_ID        = 3'd0,
    ADDR_TIMESTAMP = 3'd1,
    ADDR_FREQ      = 3'd2,
    ADDR_CYCLE_LO  = 3'd3,
    ADDR_CYCLE_HI  = 3'd4,
    ADDR_UPTIME    = 3'd5,
    ADDR_SCRATCH   = 3'd6,
    ADDR_CONTROL   = 3'd7
  } addr_e;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;
  localparam int CTRL_WRAP_BIT   = 8;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_value,
                                             input logic [31:0] new_value,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_value;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_value[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle: the master drives the access, the slave
// returns registered read data. No waitrequest.
interface nios_system_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, byteenable,
                  input  readdata);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output readdata);
endinterface

// File: rtl/nios_system_sysid_uptime.sv
// Uptime seconds counter driven by a prescaler that divides the system clock
// down to one tick per second.
module nios_system_sysid_uptime #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        freeze,
  output logic [31:0] seconds
);

  localparam int            PRESC_W   = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] prescaler;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      prescaler <= '0;
      seconds   <= '0;
    end else if (!freeze) begin
      if (prescaler == PRESC_TERM) begin
        prescaler <= '0;
        seconds   <= seconds + 32'd1;
      end else begin
        prescaler <= prescaler + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/nios_system_sysid_ext.sv
// Extended system-ID slave: constant ID words plus a free-running cycle
// counter with coherent 64-bit snapshot, uptime seconds, scratch and control.
module nios_system_sysid_ext
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1579698382,
  parameter int          CLK_FREQ_HZ = 50000000,
  parameter int          CNT_W       = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  nios_system_sysid_ext_if.slave  bus
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cycle_nxt;
  logic [HI_W-1:0]  snapshot;
  logic [31:0]      scratch;
  logic             freeze;
  logic             wrap;
  logic             wrap_event;
  logic [31:0]      uptime_sec;
  logic [31:0]      rd_value;
  logic [31:0]      lo_merged;
  logic [31:0]      hi_merged;

  logic wr_lo, wr_hi, wr_scratch, wr_ctrl, rd_lo, clear, wrap_clear;

  assign wr_lo      = bus.write && (bus.address == ADDR_CYCLE_LO);
  assign wr_hi      = bus.write && (bus.address == ADDR_CYCLE_HI);
  assign wr_scratch = bus.write && (bus.address == ADDR_SCRATCH);
  assign wr_ctrl    = bus.write && (bus.address == ADDR_CONTROL);
  assign rd_lo      = bus.read  && (bus.address == ADDR_CYCLE_LO);
  assign clear      = wr_ctrl && bus.byteenable[0] && bus.writedata[CTRL_CLEAR_BIT];
  assign wrap_clear = wr_ctrl && bus.byteenable[1] && bus.writedata[CTRL_WRAP_BIT];

  assign lo_merged = byte_merge(cycle_cnt[31:0], bus.writedata, bus.byteenable);
  assign hi_merged = byte_merge(32'(cycle_cnt[CNT_W-1:32]), bus.writedata, bus.byteenable);

  // A half-load leaves the other half untouched and suppresses the increment.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    cycle_nxt  = cycle_cnt;
    wrap_event = 1'b0;
    if (clear) begin
      cycle_nxt = '0;
    end else if (wr_lo) begin
      cycle_nxt[31:0] = lo_merged;
    end else if (wr_hi) begin
      cycle_nxt[CNT_W-1:32] = hi_merged[HI_W-1:0];
    end else if (!freeze) begin
      cycle_nxt  = cycle_cnt + CNT_W'(1);
      wrap_event = &cycle_cnt;
    end
  end

  always_comb begin
    rd_value = '0;
    case (bus.address)
      ADDR_ID:        rd_value = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_value = TIMESTAMP;
      ADDR_FREQ:      rd_value = 32'(CLK_FREQ_HZ);
      ADDR_CYCLE_LO:  rd_value = cycle_cnt[31:0];
      ADDR_CYCLE_HI:  rd_value = 32'(snapshot);
      ADDR_UPTIME:    rd_value = uptime_sec;
      ADDR_SCRATCH:   rd_value = scratch;
      ADDR_CONTROL: begin
        rd_value[CTRL_FREEZE_BIT] = freeze;
        rd_value[CTRL_WRAP_BIT]   = wrap;
      end
      default:        rd_value = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata <= '0;
      cycle_cnt    <= '0;
      snapshot     <= '0;
      scratch      <= '0;
      freeze       <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      cycle_cnt <= cycle_nxt;
      if (bus.read) bus.readdata <= rd_value;
      // Latching the upper half with the low read makes the pair coherent.
      if (rd_lo) snapshot <= cycle_cnt[CNT_W-1:32];
      if (wr_scratch) scratch <= byte_merge(scratch, bus.writedata, bus.byteenable);
      if (wr_ctrl && bus.byteenable[0]) freeze <= bus.writedata[CTRL_FREEZE_BIT];
      if (wrap_event) wrap <= 1'b1;
      else if (wrap_clear) wrap <= 1'b0;
    end
  end

  nios_system_sysid_uptime #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_uptime (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .freeze  (freeze),
    .seconds (uptime_sec)
  );

endmodule
